fp_peak_window: RTL

- Downstream consumer of the FP32 high-pass FIR output stream; takes the same valid-qualified 32-bit sample stream (no ready/backpressure).
- Per window of WIN accepted samples, reports peak absolute value, count of samples above a threshold, and a NaN flag.
- Feeds level metering and clip detection logic after the filter chain.

---
 rtl/fp_peak_window.sv | 106 ++++++++++
 1 files changed

// File: rtl/fp_peak_window.sv
// fp_peak_window: windowed level metering for an FP32 sample stream.
// Every WIN accepted samples it reports the peak magnitude, the number of
// samples whose magnitude exceeds a per-window latched threshold, and
// whether any NaN appeared. Gaps (valid_in=0) leave all state untouched.
module fp_peak_window #(
    parameter int WIN = 16,
    localparam int CNT_W = $clog2(WIN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic [31:0]      data_in,
    input  logic [31:0]      thresh,
    output logic             valid_out,
    output logic [31:0]      peak_out,
    output logic [CNT_W-1:0] over_cnt,
    output logic             nan_seen
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Running window state
    logic [CNT_W-1:0] cnt_reg;
    logic [30:0]      peak_reg;
    logic [CNT_W-1:0] over_reg;
    logic             nan_reg;
    logic [30:0]      thr_reg;

    // Registered window results
    logic             valid_out_reg;
    logic [30:0]      peak_out_reg;
    logic [CNT_W-1:0] over_out_reg;
    logic             nan_out_reg;

    // Next-state values assuming the current input is accepted
    logic [30:0]      mag;
    logic             is_nan;
    logic             first;
    logic [30:0]      thr_eff;
    logic [30:0]      peak_base;
    logic [CNT_W-1:0] over_base;
    logic             nan_base;
    logic [30:0]      peak_next;
    logic [CNT_W-1:0] over_next;
    logic             nan_next;

    // Fold the incoming sample into the running state; the first sample of a
    // window starts from a clean base so stale state is never compared.
    always_comb begin
        mag       = data_in[30:0];
        is_nan    = (&data_in[30:23]) && (|data_in[22:0]);
        first     = (cnt_reg == '0);
        thr_eff   = first ? thresh[30:0] : thr_reg;
        peak_base = first ? '0 : peak_reg;
        over_base = first ? '0 : over_reg;
        nan_base  = first ? 1'b0 : nan_reg;
        peak_next = peak_base;
        over_next = over_base;
        nan_next  = nan_base | is_nan;
        if (!is_nan && (mag > peak_base)) begin
            peak_next = mag;
        end
        if (!is_nan && (mag > thr_eff)) begin
            over_next = over_base + CNT_ONE;
        end
    end

    // Advance the window on accepted samples and register results at close
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg       <= '0;
            peak_reg      <= '0;
            over_reg      <= '0;
            nan_reg       <= 1'b0;
            thr_reg       <= '0;
            valid_out_reg <= 1'b0;
            peak_out_reg  <= '0;
            over_out_reg  <= '0;
            nan_out_reg   <= 1'b0;
        end else begin
            valid_out_reg <= 1'b0;
            if (valid_in) begin
                if (cnt_reg == LAST_IDX) begin
                    cnt_reg       <= '0;
                    valid_out_reg <= 1'b1;
                    peak_out_reg  <= peak_next;
                    over_out_reg  <= over_next;
                    nan_out_reg   <= nan_next;
                end else begin
                    cnt_reg <= cnt_reg + CNT_ONE;
                end
                peak_reg <= peak_next;
                over_reg <= over_next;
                nan_reg  <= nan_next;
                thr_reg  <= thr_eff;
            end
        end
    end

    assign valid_out = valid_out_reg;
    assign peak_out  = {1'b0, peak_out_reg};
    assign over_cnt  = over_out_reg;
    assign nan_seen  = nan_out_reg;

endmodule
